// File: rtl/fetch_pkg.sv
// Shared widths, constants and the pair-advance helper for the instruction fetch buffer.
package fetch_pkg;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;

    typedef logic [INSTR_W-1:0] instr_t;
    typedef logic [ADDR_W-1:0]  addr_t;

    localparam instr_t BUBBLE_INSTR = 32'h0;
    localparam addr_t  PC_STEP      = 32'd4;

    // Entries released by one scheduler advance: a full pair, or whatever is left.
    function automatic logic [1:0] pair_pop(input logic [31:0] occ);
        return (occ >= 32'd2) ? 2'd2 : occ[1:0];
    endfunction
endpackage

// File: rtl/fetch_ring_buffer.sv
// DEPTH-entry instruction ring: one write port, two read ports at rd_ptr and rd_ptr+1.
module fetch_ring_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [INSTR_W-1:0]     push_data,
    input  logic [1:0]             pop_count,
    output logic [INSTR_W-1:0]     instruction0,
    output logic [INSTR_W-1:0]     instruction1,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [INSTR_W-1:0] storage [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr_next;
    logic [CNT_W-1:0]   occ;

    // NOTE: storage is deliberately not reset; occ alone decides which entries are visible.
    always_ff @(posedge clk) begin
        if (push) begin
            storage[wr_ptr] <= push_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them sample pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_ptr + PTR_W'(pop_count);
            occ    <= occ + CNT_W'(push) - CNT_W'(pop_count);
        end
    end

    assign rd_ptr_next  = rd_ptr + PTR_W'(1);
    assign instruction0 = (occ != '0)          ? storage[rd_ptr]      : BUBBLE_INSTR;
    assign instruction1 = (occ >= CNT_W'(2))   ? storage[rd_ptr_next] : BUBBLE_INSTR;
    assign occupancy    = occ;
endmodule

// File: rtl/fetch_pair_buffer.sv
// Credit-limited in-order instruction fetch feeding a two-wide scheduler, with redirect flush.
module fetch_pair_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned       DEPTH           = 8,
    parameter int unsigned       MAX_OUTSTANDING = 2,
    parameter logic [ADDR_W-1:0] RESET_PC        = 32'h0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [ADDR_W-1:0]      imem_addr,
    input  logic                   imem_gnt,
    input  logic                   imem_rvalid,
    input  logic [INSTR_W-1:0]     imem_rdata,
    input  logic                   redirect,
    input  logic [ADDR_W-1:0]      redirect_pc,
    input  logic                   freeze1,
    input  logic                   freeze2,
    output logic [INSTR_W-1:0]     instruction0,
    output logic [INSTR_W-1:0]     instruction1,
    output logic                   nothing_filled,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fetch_pair_buffer: DEPTH must be a power of two and at least 4");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > DEPTH) begin : g_bad_outstanding
        $error("fetch_pair_buffer: MAX_OUTSTANDING must lie in 1..DEPTH");
    end

    logic [ADDR_W-1:0] pc;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  discard;
    logic [SUM_W-1:0]  credit_used;
    logic              accept;
    logic              push;
    logic [1:0]        pop_count;

    // Credits count every word already held plus every word still owed by memory.
    assign credit_used = SUM_W'(occupancy) + SUM_W'(inflight);
    assign imem_req    = rst && !redirect
                         && (credit_used < SUM_W'(DEPTH))
                         && (inflight < CNT_W'(MAX_OUTSTANDING));
    assign imem_addr   = pc;
    assign accept      = imem_req && imem_gnt;
    assign push        = imem_rvalid && !redirect && (discard == '0);

    always_comb begin
        // NOTE: default assigned first so every path drives pop_count and no latch is inferred.
        pop_count = 2'd0;
        if (!freeze1 && !freeze2 && !redirect) begin
            pop_count = pair_pop(32'(occupancy));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc       <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
        end else begin
            inflight <= inflight + CNT_W'(accept) - CNT_W'(imem_rvalid);
            if (redirect) begin
                pc      <= redirect_pc;
                // inflight already includes words owed to earlier redirects: all of it is now stale.
                discard <= inflight - CNT_W'(imem_rvalid);
            end else begin
                if (accept) begin
                    pc <= pc + PC_STEP;
                end
                if (imem_rvalid && (discard != '0)) begin
                    discard <= discard - CNT_W'(1);
                end
            end
        end
    end

    fetch_ring_buffer #(
        .DEPTH(DEPTH)
    ) u_ring (
        .clk         (clk),
        .rst         (rst),
        .flush       (redirect),
        .push        (push),
        .push_data   (imem_rdata),
        .pop_count   (pop_count),
        .instruction0(instruction0),
        .instruction1(instruction1),
        .occupancy   (occupancy)
    );

    assign nothing_filled = (occupancy == '0);
endmodule

// File: tb/tb_fetch_pair_buffer.sv
// Randomised bench for fetch_pair_buffer against a queue-based model of the fetch buffer.
module tb_fetch_pair_buffer;
    localparam int unsigned DEPTH    = 8;
    localparam int unsigned MAX_OUT  = 2;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] TAG      = 32'hA000_0000;

    typedef struct packed {
        logic [31:0] addr;
        logic        dead;
    } pend_t;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        freeze1;
    logic        freeze2;
    logic [31:0] instruction0;
    logic [31:0] instruction1;
    logic        nothing_filled;
    logic [3:0]  occupancy;

    // Reference model: words held in order, requests owed by memory, and the fetch PC.
    logic [31:0] fifo[$];
    pend_t       pend[$];
    logic [31:0] m_pc;
    int          n_checks;
    int          n_fail;
    int          gnt_pct;
    int          rsp_pct;

    fetch_pair_buffer #(
        .DEPTH          (DEPTH),
        .MAX_OUTSTANDING(MAX_OUT),
        .RESET_PC       (RESET_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .freeze1       (freeze1),
        .freeze2       (freeze2),
        .instruction0  (instruction0),
        .instruction1  (instruction1),
        .nothing_filled(nothing_filled),
        .occupancy     (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, act, exp);
        end
    endtask

    function automatic bit any_dead();
        foreach (pend[i]) begin
            if (pend[i].dead) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic compare_state();
        logic [31:0] e0;
        logic [31:0] e1;
        e0 = (fifo.size() > 0) ? fifo[0] : 32'h0;
        e1 = (fifo.size() > 1) ? fifo[1] : 32'h0;
        check("instruction0", instruction0, e0);
        check("instruction1", instruction1, e1);
        check("occupancy", 32'(occupancy), 32'(fifo.size()));
        check("nothing_filled", 32'(nothing_filled), 32'(fifo.size() == 0));
    endtask

    // Called at a falling edge: drive one cycle of stimulus, advance the model, land on the next falling edge.
    task automatic cycle(input bit f1, input bit f2, input bit redir, input logic [31:0] rpc);
        pend_t rsp;
        bit    g;
        bit    rv;
        bit    exp_req;
        bit    accept;
        bit    push;
        int    npop;
        rsp = '0;
        g   = ($urandom_range(99) < gnt_pct);
        rv  = (pend.size() > 0) && ($urandom_range(99) < rsp_pct);
        freeze1     = f1;
        freeze2     = f2;
        redirect    = redir;
        redirect_pc = rpc;
        imem_gnt    = g;
        imem_rvalid = rv;
        imem_rdata  = rv ? (pend[0].addr | TAG) : $urandom();
        #1;
        exp_req = !redir && (fifo.size() + pend.size() < DEPTH) && (pend.size() < MAX_OUT);
        check("imem_req", 32'(imem_req), 32'(exp_req));
        check("imem_addr", imem_addr, m_pc);
        accept = exp_req && g;
        if (rv) rsp = pend.pop_front();
        push = rv && !redir && !rsp.dead;
        check("no_overflow", 32'(push && (int'(occupancy) == DEPTH)), 32'h0);
        if (redir) begin
            fifo.delete();
            foreach (pend[i]) pend[i].dead = 1'b1;
            m_pc = rpc;
        end else begin
            if (!f1 && !f2) begin
                npop = (fifo.size() < 2) ? fifo.size() : 2;
                repeat (npop) void'(fifo.pop_front());
            end
            if (push) fifo.push_back(rsp.addr | TAG);
            if (accept) begin
                pend.push_back('{addr: m_pc, dead: 1'b0});
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
        compare_state();
    endtask

    initial begin
        bit          f1;
        bit          f2;
        bit          redir;
        logic [31:0] rpc;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        redirect = 1'b0; redirect_pc = 32'h0; freeze1 = 1'b0; freeze2 = 1'b0;
        m_pc = RESET_PC;
        repeat (3) @(negedge clk);
        compare_state();
        check("reset_imem_req", 32'(imem_req), 32'h0);
        check("reset_imem_addr", imem_addr, RESET_PC);

        // Reset release and first pair, freezes high to hold it.
        rst = 1'b1;
        gnt_pct = 100; rsp_pct = 100;
        cycle(1, 1, 0, 32'h0);
        check("first_empty", 32'(nothing_filled), 32'h1);
        cycle(1, 1, 0, 32'h0);
        check("first_filled", 32'(nothing_filled), 32'h0);
        check("first_i0", instruction0, 32'hA000_0000);
        check("first_i1_bubble", instruction1, 32'h0);
        cycle(1, 1, 0, 32'h0);
        check("first_i1", instruction1, 32'hA000_0004);

        // Fill to full.
        repeat (12) cycle(1, 1, 0, 32'h0);
        check("full_occ", 32'(occupancy), 32'd8);
        check("full_req_low", 32'(imem_req), 32'h0);
        check("full_i0", instruction0, 32'hA000_0000);
        check("full_i1", instruction1, 32'hA000_0004);

        // Single entry.
        gnt_pct = 0;
        cycle(1, 1, 1, 32'h40);
        check("flush_empty", 32'(nothing_filled), 32'h1);
        check("flush_addr", imem_addr, 32'h40);
        gnt_pct = 100;
        cycle(1, 1, 0, 32'h0);
        gnt_pct = 0;
        cycle(1, 1, 0, 32'h0);
        check("single_i0", instruction0, 32'hA000_0040);
        check("single_i1", instruction1, 32'h0);
        check("single_filled", 32'(nothing_filled), 32'h0);
        cycle(0, 0, 0, 32'h0);
        check("single_drained", 32'(nothing_filled), 32'h1);
        check("single_drained_i0", instruction0, 32'h0);
        check("single_drained_occ", 32'(occupancy), 32'h0);

        // Partial freeze holds the pair.
        gnt_pct = 100;
        for (int k = 0; k < 20 && fifo.size() != 4; k++) cycle(1, 1, 0, 32'h0);
        check("pf_occ", 32'(occupancy), 32'd4);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 1, 0, 32'h0);
            check("pf_i0", instruction0, 32'hA000_0044);
            check("pf_i1", instruction1, 32'hA000_0048);
            check("pf_no_pop", 32'(occupancy >= 4'd4), 32'h1);
        end

        // Redirect with two requests in flight.
        gnt_pct = 0;
        for (int k = 0; k < 10 && pend.size() != 0; k++) cycle(1, 1, 0, 32'h0);
        cycle(1, 1, 1, 32'h200);
        gnt_pct = 100; rsp_pct = 0;
        for (int k = 0; k < 10 && pend.size() != 2; k++) cycle(1, 1, 0, 32'h0);
        check("two_inflight_req", 32'(imem_req), 32'h0);
        gnt_pct = 0;
        cycle(1, 1, 1, 32'h100);
        check("redir_addr", imem_addr, 32'h100);
        check("redir_empty", 32'(nothing_filled), 32'h1);
        rsp_pct = 100;
        repeat (2) begin
            cycle(1, 1, 0, 32'h0);
            check("redir_drop", 32'(occupancy), 32'h0);
        end
        gnt_pct = 100;
        for (int k = 0; k < 10 && fifo.size() == 0; k++) cycle(1, 1, 0, 32'h0);
        check("redir_first_i0", instruction0, 32'hA000_0100);

        // Asynchronous reset mid-fill.
        for (int k = 0; k < 20 && fifo.size() != 5; k++) cycle(1, 1, 0, 32'h0);
        check("mid_occ", 32'(occupancy), 32'd5);
        #2 rst = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect = 1'b0;
        fifo.delete(); pend.delete(); m_pc = RESET_PC;
        #1;
        compare_state();
        check("arst_imem_req", 32'(imem_req), 32'h0);
        check("arst_imem_addr", imem_addr, RESET_PC);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        cycle(1, 1, 0, 32'h0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                gnt_pct = $urandom_range(100, 30);
                rsp_pct = $urandom_range(100, 30);
            end
            f1    = ($urandom_range(3) == 0);
            f2    = ($urandom_range(3) == 0);
            redir = ($urandom_range(31) == 0) && !any_dead();
            rpc   = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC);
            cycle(f1, f2, redir, rpc);
        end

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end
endmodule
